vga_fetch_scheduler: RTL and testbench

AXI read-side sequencer that keeps the VGA ping/pong line buffers filled from SDRAM. It walks the frame region base..top in fixed 256-byte bursts, drives the AR/R handshakes, and steers each accepted beat to a buffer bank and word index. It tracks per-bank full/empty state, which the display side releases with consume pulses. It sits in the AXI clock domain between the config unit, the AXI master port and the ping-pong buffer storage.

---
 rtl/vga_fetch_scheduler.sv | 170 +++++++++++++++++
 tb/tb_vga_fetch_scheduler.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fetch_scheduler.sv
// AXI read sequencer that keeps the VGA ping/pong line buffers filled.
// Walks base..top in fixed-size bursts, steers each read beat to a bank
// and word index, and tracks per-bank full flags that the display side
// clears with consume pulses. A failed burst is counted and refetched.
module vga_fetch_scheduler #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int BURST_LEN  = 32,   // power of two, 2..256
  parameter int ERR_W      = 8
) (
  input  logic                         clk_a,
  input  logic                         reset_a,
  input  logic                         enable_i,
  input  logic [ADDR_WIDTH-1:0]        base_addr_i,
  input  logic [ADDR_WIDTH-1:0]        top_addr_i,
  input  logic [1:0]                   bank_consumed_i,
  input  logic                         arready_i,
  output logic                         arvalid_o,
  output logic [ADDR_WIDTH-1:0]        araddr_o,
  output logic [7:0]                   arlen_o,
  output logic [2:0]                   arsize_o,
  output logic [1:0]                   arburst_o,
  input  logic                         rvalid_i,
  input  logic [1:0]                   rresp_i,
  input  logic                         rlast_i,
  output logic                         rready_o,
  output logic                         wr_en_o,
  output logic                         wr_bank_o,
  output logic [$clog2(BURST_LEN)-1:0] wr_idx_o,
  output logic [1:0]                   bank_full_o,
  output logic                         frame_start_o,
  output logic [ERR_W-1:0]             err_cnt_o,
  output logic                         busy_o
);

  localparam int IDX_W = $clog2(BURST_LEN);
  localparam int STEP  = BURST_LEN * (DATA_WIDTH / 8);
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(BURST_LEN - 1);
  // Step kept one bit wider so the wrap compare never sees an overflowed sum.
  localparam logic [ADDR_WIDTH:0]   STEP_X   = (ADDR_WIDTH + 1)'(STEP);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_BANK,
    S_ADDR,
    S_DATA,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   base_q, top_q, next_addr_q;
  logic                    fill_ptr_q;
  logic [IDX_W-1:0]        beat_cnt_q;
  logic                    bad_q;
  logic [1:0]              bank_full_q;
  logic [ERR_W-1:0]        err_cnt_q;

  logic                    ar_hs;
  logic                    r_beat;
  logic                    last_beat;
  logic                    beat_bad;
  logic [ADDR_WIDTH:0]     addr_sum;
  logic                    addr_wrap;
  logic [1:0]              set_mask;

  assign ar_hs     = (state_q == S_ADDR) && arready_i;
  assign r_beat    = (state_q == S_DATA) && rvalid_i;
  // The final counted beat ends the burst even without rlast; an early
  // rlast also ends it, but leaves the bank short, so the burst is bad.
  assign last_beat = r_beat && ((beat_cnt_q == LAST_IDX) || rlast_i);
  assign beat_bad  = r_beat && ((rresp_i != 2'b00) || (rlast_i && (beat_cnt_q != LAST_IDX)));
  assign addr_sum  = {1'b0, next_addr_q} + STEP_X;
  assign addr_wrap = addr_sum >= {1'b0, top_q};
  // Set wins over a simultaneous consume because it is OR-ed in last.
  assign set_mask  = ((state_q == S_DONE) && !bad_q) ? (2'b01 << fill_ptr_q) : 2'b00;

  // State register.
  always_ff @(posedge clk_a) begin
    // NOTE: non-blocking assignments for all state so every register samples pre-edge values together.
    if (reset_a) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (enable_i) state_d = S_WAIT_BANK;
      S_WAIT_BANK: begin
        if (!enable_i)                      state_d = S_IDLE;
        else if (!bank_full_q[fill_ptr_q])  state_d = S_ADDR;
      end
      // arvalid is never withdrawn: enable is ignored until the burst is over.
      S_ADDR:      if (arready_i) state_d = S_DATA;
      S_DATA:      if (last_beat) state_d = S_DONE;
      S_DONE:      state_d = S_WAIT_BANK;
      default:     state_d = S_IDLE;
    endcase
  end

  // Handshake and buffer-write outputs decoded from the current state.
  always_comb begin
    arvalid_o     = 1'b0;
    frame_start_o = 1'b0;
    rready_o      = 1'b0;
    wr_en_o       = 1'b0;
    case (state_q)
      S_ADDR: begin
        arvalid_o     = 1'b1;
        frame_start_o = arready_i && (next_addr_q == base_q);
      end
      S_DATA: begin
        rready_o = 1'b1;
        wr_en_o  = rvalid_i;
      end
      default: ;
    endcase
  end

  // Frame window, address walk, beat counting, bank flags and error count.
  always_ff @(posedge clk_a) begin
    if (reset_a) begin
      base_q      <= '0;
      top_q       <= '0;
      next_addr_q <= '0;
      fill_ptr_q  <= 1'b0;
      beat_cnt_q  <= '0;
      bad_q       <= 1'b0;
      bank_full_q <= 2'b00;
      err_cnt_q   <= '0;
    end else begin
      // The window is captured only when leaving IDLE; later config edits wait for the next enable.
      if ((state_q == S_IDLE) && enable_i) begin
        base_q      <= base_addr_i;
        top_q       <= top_addr_i;
        next_addr_q <= base_addr_i;
      end
      if (ar_hs) begin
        beat_cnt_q <= '0;
        bad_q      <= 1'b0;
      end
      if (r_beat) begin
        beat_cnt_q <= beat_cnt_q + IDX_W'(1);
        if (beat_bad) bad_q <= 1'b1;
      end
      if (state_q == S_DONE) begin
        if (bad_q) begin
          // Bad burst: pointer and address stay put so the same line is refetched.
          if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + ERR_W'(1);
        end else begin
          fill_ptr_q  <= ~fill_ptr_q;
          next_addr_q <= addr_wrap ? base_q : addr_sum[ADDR_WIDTH-1:0];
        end
      end
      bank_full_q <= (bank_full_q & ~bank_consumed_i) | set_mask;
    end
  end

  assign araddr_o    = next_addr_q;
  assign arlen_o     = 8'(BURST_LEN - 1);
  assign arsize_o    = 3'd3;
  assign arburst_o   = 2'd1;
  assign wr_bank_o   = fill_ptr_q;
  assign wr_idx_o    = beat_cnt_q;
  assign bank_full_o = bank_full_q;
  assign err_cnt_o   = err_cnt_q;
  assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_vga_fetch_scheduler.sv
// Self-checking bench for vga_fetch_scheduler: a directed table for the
// basic fill, wrap, retry and backpressure cases, hand sequences for the
// consume race, enable drop and reset, then randomized bursts checked
// against a transaction-level model of the frame walk and bank flags.
module tb_vga_fetch_scheduler;

  localparam int BL      = 32;
  localparam int STEP    = 256;
  localparam int ERR_MAX = 255;

  logic        clk_a = 1'b0;
  logic        reset_a = 1'b1;
  logic        enable_i = 1'b0;
  logic [63:0] base_addr_i = '0;
  logic [63:0] top_addr_i = '0;
  logic [1:0]  bank_consumed_i = '0;
  logic        arready_i = 1'b0;
  logic        arvalid_o;
  logic [63:0] araddr_o;
  logic [7:0]  arlen_o;
  logic [2:0]  arsize_o;
  logic [1:0]  arburst_o;
  logic        rvalid_i = 1'b0;
  logic [1:0]  rresp_i = '0;
  logic        rlast_i = 1'b0;
  logic        rready_o;
  logic        wr_en_o;
  logic        wr_bank_o;
  logic [4:0]  wr_idx_o;
  logic [1:0]  bank_full_o;
  logic        frame_start_o;
  logic [7:0]  err_cnt_o;
  logic        busy_o;

  vga_fetch_scheduler dut (
    .clk_a           (clk_a),
    .reset_a         (reset_a),
    .enable_i        (enable_i),
    .base_addr_i     (base_addr_i),
    .top_addr_i      (top_addr_i),
    .bank_consumed_i (bank_consumed_i),
    .arready_i       (arready_i),
    .arvalid_o       (arvalid_o),
    .araddr_o        (araddr_o),
    .arlen_o         (arlen_o),
    .arsize_o        (arsize_o),
    .arburst_o       (arburst_o),
    .rvalid_i        (rvalid_i),
    .rresp_i         (rresp_i),
    .rlast_i         (rlast_i),
    .rready_o        (rready_o),
    .wr_en_o         (wr_en_o),
    .wr_bank_o       (wr_bank_o),
    .wr_idx_o        (wr_idx_o),
    .bank_full_o     (bank_full_o),
    .frame_start_o   (frame_start_o),
    .err_cnt_o       (err_cnt_o),
    .busy_o          (busy_o)
  );

  always #5 clk_a = ~clk_a;

  // One burst: stimulus knobs plus the values the DUT must show.
  // gap: 0 = back-to-back beats, 1 = one idle cycle before each beat, 2 = random idles.
  typedef struct {
    logic [1:0]  cons;        // consume pulse issued before the burst
    int          ar_delay;    // cycles arready stays low once arvalid is seen
    int          err_beat;    // beat carrying rresp=2, -1 for none
    int          early_last;  // beat carrying rlast (ends burst), -1 for beat 31
    int          gap;
    logic [1:0]  cons_done;   // consume pulse driven during the DONE cycle
    logic [63:0] addr;
    bit          fs;
    bit          bank;
    logic [1:0]  exp_full;
    int          exp_err;
  } vec_t;

  int n_total = 0;
  int n_bad   = 0;

  // Transaction-level model state.
  logic [63:0] m_base, m_top, m_addr;
  bit          m_ptr;
  logic [1:0]  m_full;
  int          m_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_arvalid"}, arvalid_o, 0);
    check({tag, "_araddr"}, araddr_o, 0);
    check({tag, "_arlen"}, arlen_o, BL - 1);
    check({tag, "_arsize"}, arsize_o, 3);
    check({tag, "_arburst"}, arburst_o, 1);
    check({tag, "_rready"}, rready_o, 0);
    check({tag, "_wr_en"}, wr_en_o, 0);
    check({tag, "_wr_bank"}, wr_bank_o, 0);
    check({tag, "_wr_idx"}, wr_idx_o, 0);
    check({tag, "_bank_full"}, bank_full_o, 0);
    check({tag, "_frame_start"}, frame_start_o, 0);
    check({tag, "_err_cnt"}, err_cnt_o, 0);
    check({tag, "_busy"}, busy_o, 0);
  endtask

  task automatic pulse_consume(input logic [1:0] msk);
    if (msk != 2'b00) begin
      @(negedge clk_a);
      bank_consumed_i = msk;
      @(negedge clk_a);
      bank_consumed_i = 2'b00;
      m_full = m_full & ~msk;
    end
  endtask

  task automatic wait_arvalid(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      #1;
      if (arvalid_o) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk_a);
    end
    if (!ok) check("ar_timeout", arvalid_o, 1);
  endtask

  task automatic do_burst(input vec_t v);
    int nb;
    int g;
    bit ok;
    nb = (v.early_last >= 0) ? v.early_last + 1 : BL;
    wait_arvalid(ok);
    if (!ok) return;
    for (int d = 0; d < v.ar_delay; d++) begin
      check("ar_hold_valid", arvalid_o, 1);
      check("ar_hold_addr", araddr_o, v.addr);
      check("ar_hold_fs", frame_start_o, 0);
      @(negedge clk_a);
      #1;
    end
    arready_i = 1'b1;
    #1;
    check("araddr", araddr_o, v.addr);
    check("frame_start", frame_start_o, v.fs);
    @(negedge clk_a);
    arready_i = 1'b0;
    for (int i = 0; i < nb; i++) begin
      g = (v.gap == 1) ? 1 : (v.gap == 2) ? $urandom_range(0, 2) : 0;
      for (int k = 0; k < g; k++) begin
        rvalid_i = 1'b0;
        #1;
        check("gap_wr_en", wr_en_o, 0);
        check("gap_rready", rready_o, 1);
        @(negedge clk_a);
      end
      rvalid_i = 1'b1;
      rresp_i  = (i == v.err_beat) ? 2'd2 : 2'd0;
      rlast_i  = (i == nb - 1);
      #1;
      check("beat_wr_en", wr_en_o, 1);
      check("beat_wr_bank", wr_bank_o, v.bank);
      check("beat_wr_idx", wr_idx_o, i[4:0]);
      @(negedge clk_a);
    end
    rvalid_i        = 1'b0;
    rlast_i         = 1'b0;
    rresp_i         = 2'd0;
    bank_consumed_i = v.cons_done;
    #1;
    check("done_rready", rready_o, 0);
    @(negedge clk_a);
    bank_consumed_i = 2'b00;
    #1;
    check("bank_full", bank_full_o, v.exp_full);
    check("err_cnt", err_cnt_o, v.exp_err);
  endtask

  task automatic do_reset();
    @(negedge clk_a);
    reset_a  = 1'b1;
    enable_i = 1'b0;
    @(negedge clk_a);
    reset_a = 1'b0;
    m_full  = 2'b00;
    m_ptr   = 1'b0;
    m_err   = 0;
  endtask

  task automatic start_frame(input logic [63:0] b, input logic [63:0] t);
    @(negedge clk_a);
    base_addr_i = b;
    top_addr_i  = t;
    enable_i    = 1'b1;
    m_base = b;
    m_top  = t;
    m_addr = b;
  endtask

  // Builds one burst from the model, runs it, and advances the model.
  task automatic model_burst(input int force_last);
    vec_t        v;
    int          nb;
    bit          bad;
    logic [64:0] sum;
    if (m_full[m_ptr]) pulse_consume(m_ptr ? 2'b10 : 2'b01);
    if ($urandom_range(0, 2) == 0) pulse_consume(m_ptr ? 2'b01 : 2'b10);
    v.cons       = 2'b00;
    v.cons_done  = 2'b00;
    v.ar_delay   = $urandom_range(0, 3);
    v.gap        = $urandom_range(0, 1) * 2;
    v.err_beat   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, BL - 1)) : -1;
    v.early_last = (force_last >= 0) ? force_last :
                   ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, BL - 2)) : -1;
    v.addr = m_addr;
    v.fs   = (m_addr == m_base);
    v.bank = m_ptr;
    nb  = (v.early_last >= 0) ? v.early_last + 1 : BL;
    bad = (v.err_beat >= 0 && v.err_beat < nb) || (v.early_last >= 0 && v.early_last < BL - 1);
    if (bad) begin
      m_err = (m_err == ERR_MAX) ? ERR_MAX : m_err + 1;
    end else begin
      m_full[m_ptr] = 1'b1;
      m_ptr = ~m_ptr;
      sum = {1'b0, m_addr} + 65'(STEP);
      m_addr = (sum >= {1'b0, m_top}) ? m_base : sum[63:0];
    end
    v.exp_full = m_full;
    v.exp_err  = m_err;
    do_burst(v);
  endtask

  vec_t tbl [9];

  initial begin
    int  stall_cnt;
    bit  ok;
    logic [63:0] b;

    // Fields: cons, ar_delay, err_beat, early_last, gap, cons_done, addr, fs, bank, exp_full, exp_err
    tbl[0] = '{2'b00, 0, -1, -1, 0, 2'b00, 64'h1000, 1'b1, 1'b0, 2'b01, 0};
    tbl[1] = '{2'b00, 0, -1, -1, 0, 2'b00, 64'h1100, 1'b0, 1'b1, 2'b11, 0};
    tbl[2] = '{2'b01, 1, -1, -1, 0, 2'b00, 64'h1200, 1'b0, 1'b0, 2'b11, 0};
    tbl[3] = '{2'b10, 0, -1, -1, 0, 2'b00, 64'h1300, 1'b0, 1'b1, 2'b11, 0};
    tbl[4] = '{2'b01, 0, -1, -1, 0, 2'b00, 64'h1000, 1'b1, 1'b0, 2'b11, 0};
    tbl[5] = '{2'b10, 0,  7, -1, 0, 2'b00, 64'h1100, 1'b0, 1'b1, 2'b01, 1};
    tbl[6] = '{2'b00, 5, -1, -1, 1, 2'b00, 64'h1100, 1'b0, 1'b1, 2'b11, 1};
    tbl[7] = '{2'b01, 0, -1, 10, 0, 2'b00, 64'h1200, 1'b0, 1'b0, 2'b10, 2};
    tbl[8] = '{2'b00, 2, -1, -1, 1, 2'b00, 64'h1200, 1'b0, 1'b0, 2'b11, 2};

    m_full = 2'b00;
    m_ptr  = 1'b0;
    m_err  = 0;
    repeat (3) @(negedge clk_a);
    #1;
    check_reset_outputs("rst");
    reset_a = 1'b0;

    // Basic fill, stall, wrap, error retry, early rlast, backpressure.
    start_frame(64'h1000, 64'h1400);
    for (int i = 0; i < 2; i++) begin
      pulse_consume(tbl[i].cons);
      do_burst(tbl[i]);
    end
    stall_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_a);
      #1;
      if (arvalid_o) stall_cnt++;
    end
    check("stall_no_ar", stall_cnt, 0);
    check("stall_busy", busy_o, 1);
    for (int i = 2; i < 9; i++) begin
      pulse_consume(tbl[i].cons);
      do_burst(tbl[i]);
    end

    // Reset in the middle of a burst returns every output to its reset value.
    pulse_consume(2'b10);
    wait_arvalid(ok);
    check("mid_araddr", araddr_o, 64'h1300);
    arready_i = 1'b1;
    @(negedge clk_a);
    arready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rvalid_i = 1'b1;
      @(negedge clk_a);
    end
    rvalid_i = 1'b0;
    reset_a  = 1'b1;
    enable_i = 1'b0;
    @(negedge clk_a);
    #1;
    check_reset_outputs("mid_rst");
    reset_a = 1'b0;
    m_full = 2'b00;
    m_ptr  = 1'b0;
    m_err  = 0;

    // Consume on an empty bank is ignored; set wins over a same-cycle consume.
    start_frame(64'h1000, 64'h1400);
    pulse_consume(2'b10);
    #1;
    check("race_empty_consume", bank_full_o, 2'b00);
    do_burst('{2'b00, 0, -1, -1, 0, 2'b01, 64'h1000, 1'b1, 1'b0, 2'b01, 0});

    // Dropping enable while arvalid is up: the AR and burst still complete, then IDLE.
    wait_arvalid(ok);
    enable_i = 1'b0;
    repeat (3) @(negedge clk_a);
    #1;
    check("en_drop_arvalid", arvalid_o, 1);
    check("en_drop_araddr", araddr_o, 64'h1100);
    do_burst('{2'b00, 1, -1, -1, 0, 2'b00, 64'h1100, 1'b0, 1'b1, 2'b11, 0});
    repeat (2) @(negedge clk_a);
    #1;
    check("en_drop_busy", busy_o, 0);
    check("en_drop_idle_arvalid", arvalid_o, 0);

    // Randomized frames, including a degenerate window and one at the top of the address space.
    for (int cfg = 0; cfg < 5; cfg++) begin
      do_reset();
      if (cfg == 0) begin
        start_frame(64'hFFFF_FFFF_FFFF_FC00, 64'hFFFF_FFFF_FFFF_FFF0);
      end else if (cfg == 1) begin
        start_frame(64'h0000_0000_0000_4000, 64'h0000_0000_0000_4080);
      end else begin
        b = {$urandom, $urandom};
        b[63] = 1'b0;
        b[7:0] = 8'h00;
        start_frame(b, b + 64'($urandom_range(0, 1500)));
      end
      for (int n = 0; n < 14; n++) model_burst(-1);
    end

    // Error counter saturation: every burst ends on an early rlast.
    do_reset();
    start_frame(64'h3000, 64'h3000);
    for (int n = 0; n < ERR_MAX + 4; n++) model_burst(0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    repeat (90000) @(posedge clk_a);
    $display("FAIL watchdog: cycle budget exhausted, total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
